// File: rtl/tetris_pkg.sv
// ----------------------------------------------------------------------------
// tetris_pkg
// Shared types for the tetrimino mover: move commands, mover FSM states,
// board coordinate types and a couple of coordinate helpers.
// ----------------------------------------------------------------------------
package tetris_pkg;

    localparam int BOARD_DIM = 8;

    typedef logic        [2:0] coord_t;
    typedef logic signed [3:0] scoord_t;

    typedef enum logic [1:0] {
        CMD_LEFT  = 2'd0,
        CMD_RIGHT = 2'd1,
        CMD_DOWN  = 2'd2,
        CMD_ROT   = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_CHECK   = 2'd2,
        ST_RESOLVE = 2'd3
    } mover_state_t;

    function automatic scoord_t widen(input coord_t c);
        return scoord_t'({1'b0, c});
    endfunction

    // Every candidate a translation or rotation can produce lies in -7..14.
    // In 4-bit two's complement the off-board values (-7..-1 and 8..14) all
    // land in the negative half, so the sign bit alone flags them and no
    // value ever wraps back onto the board.
    function automatic logic on_board(input scoord_t v);
        return !v[3];
    endfunction

endpackage

// File: rtl/tetrimino_candidate.sv
// ----------------------------------------------------------------------------
// tetrimino_candidate
// Combinational generator of the four candidate block positions for a move
// command, plus a per-block off-board flag.
//   cur_x / cur_y   : current piece rows / columns
//   cmd             : LEFT, RIGHT, DOWN or ROT (clockwise about PIVOT_IDX)
//   cand_x / cand_y : candidate rows / columns (low 3 bits)
//   oob             : per-block flag, candidate row or column off the board
// ----------------------------------------------------------------------------
module tetrimino_candidate
    import tetris_pkg::*;
#(
    parameter int PIVOT_IDX = 1
)
(
    input  logic [3:0][2:0] cur_x,
    input  logic [3:0][2:0] cur_y,
    input  cmd_t            cmd,
    output logic [3:0][2:0] cand_x,
    output logic [3:0][2:0] cand_y,
    output logic [3:0]      oob
);

    localparam logic [1:0] PIV = 2'(PIVOT_IDX);

    scoord_t pr, pc;
    scoord_t r, c, dr, dc, nr, nc;

    always_comb begin
        cand_x = '0;
        cand_y = '0;
        oob    = '0;
        pr     = widen(cur_x[PIV]);
        pc     = widen(cur_y[PIV]);
        r      = '0;
        c      = '0;
        dr     = '0;
        dc     = '0;
        nr     = '0;
        nc     = '0;
        for (int k = 0; k < 4; k++) begin
            r  = widen(cur_x[k]);
            c  = widen(cur_y[k]);
            dr = r - pr;
            dc = c - pc;
            nr = r;
            nc = c;
            case (cmd)
                CMD_LEFT:  nc = c - 4'sd1;
                CMD_RIGHT: nc = c + 4'sd1;
                CMD_DOWN:  nr = r + 4'sd1;
                CMD_ROT: begin
                    // clockwise in (row down, col right) screen coordinates
                    nr = pr + dc;
                    nc = pc - dr;
                end
                default: ;
            endcase
            cand_x[k] = nr[2:0];
            cand_y[k] = nc[2:0];
            oob[k]    = !on_board(nr) || !on_board(nc);
        end
    end

endmodule

// File: rtl/tetrimino_mover.sv
// ----------------------------------------------------------------------------
// tetrimino_mover
// Holds the active tetrimino, validates load and move requests one block per
// cycle against the settled board, and commits or rejects them.
//   clk, reset_n          : clock, asynchronous active-low reset
//   load, inX, inY        : new piece from the encoder (taken when load_ready)
//   load_ready            : mover is idle
//   cmd_valid, cmd        : move command (taken when cmd_ready)
//   cmd_ready             : idle with an active piece
//   board                 : settled cells, board[row][col]
//   outX, outY            : committed piece rows / columns
//   piece_valid           : an active piece is held
//   moved, blocked        : one-cycle result pulses for a command
//   locked                : DOWN was blocked and the piece was retired
//   game_over             : a freshly loaded piece overlapped the board
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for load or a move command
// ST_CALC    | register the candidate positions for the latched command
// ST_CHECK   | test one candidate block per cycle, accumulate a fail flag
// ST_RESOLVE | commit or reject, emit result pulses
// ----------------------------------------------------------------------------
module tetrimino_mover
    import tetris_pkg::*;
#(
    parameter int PIVOT_IDX    = 1,
    parameter int LOCK_ON_DOWN = 1
)
(
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  load,
    input  logic [3:0][2:0]                       inX,
    input  logic [3:0][2:0]                       inY,
    output logic                                  load_ready,
    input  logic                                  cmd_valid,
    input  logic [1:0]                            cmd,
    output logic                                  cmd_ready,
    input  logic [BOARD_DIM-1:0][BOARD_DIM-1:0]   board,
    output logic [3:0][2:0]                       outX,
    output logic [3:0][2:0]                       outY,
    output logic                                  piece_valid,
    output logic                                  moved,
    output logic                                  blocked,
    output logic                                  locked,
    output logic                                  game_over
);

    mover_state_t    state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic            is_load_q, is_load_d;
    logic            fail_q, fail_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0][2:0] cand_x_q, cand_x_d;
    logic [3:0][2:0] cand_y_q, cand_y_d;
    logic [3:0]      oob_q, oob_d;
    logic [3:0][2:0] out_x_q, out_x_d;
    logic [3:0][2:0] out_y_q, out_y_d;
    logic            piece_valid_q, piece_valid_d;
    logic            moved_q, moved_d;
    logic            blocked_q, blocked_d;
    logic            locked_q, locked_d;
    logic            game_over_q, game_over_d;

    logic [3:0][2:0] gen_x, gen_y;
    logic [3:0]      gen_oob;
    logic [1:0]      chk_idx;
    logic            blk_fail;

    tetrimino_candidate #(
        .PIVOT_IDX (PIVOT_IDX)
    ) u_candidate (
        .cur_x  (out_x_q),
        .cur_y  (out_y_q),
        .cmd    (cmd_q),
        .cand_x (gen_x),
        .cand_y (gen_y),
        .oob    (gen_oob)
    );

    // cnt_q counts down 3..0 through CHECK, so block k = 3 - cnt_q.
    // An off-board block still produces an in-range (truncated) board index;
    // its oob flag forces the failure regardless of the board bit.
    always_comb begin
        chk_idx  = 2'd3 - cnt_q;
        blk_fail = oob_q[chk_idx] | board[cand_x_q[chk_idx]][cand_y_q[chk_idx]];
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        is_load_d     = is_load_q;
        fail_d        = fail_q;
        cnt_d         = cnt_q;
        cand_x_d      = cand_x_q;
        cand_y_d      = cand_y_q;
        oob_d         = oob_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        piece_valid_d = piece_valid_q;
        moved_d       = 1'b0;
        blocked_d     = 1'b0;
        locked_d      = 1'b0;
        game_over_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    cand_x_d  = inX;
                    cand_y_d  = inY;
                    oob_d     = '0;
                    is_load_d = 1'b1;
                    fail_d    = 1'b0;
                    cnt_d     = 2'd3;
                    state_d   = ST_CHECK;
                end else if (cmd_valid && piece_valid_q) begin
                    cmd_d     = cmd_t'(cmd);
                    is_load_d = 1'b0;
                    state_d   = ST_CALC;
                end
            end

            ST_CALC: begin
                cand_x_d = gen_x;
                cand_y_d = gen_y;
                oob_d    = gen_oob;
                fail_d   = 1'b0;
                cnt_d    = 2'd3;
                state_d  = ST_CHECK;
            end

            ST_CHECK: begin
                fail_d = fail_q | blk_fail;
                cnt_d  = cnt_q - 2'd1;
                if (cnt_q == 2'd0) begin
                    state_d = ST_RESOLVE;
                end
            end

            ST_RESOLVE: begin
                state_d = ST_IDLE;
                if (is_load_q) begin
                    if (fail_q) begin
                        game_over_d   = 1'b1;
                        piece_valid_d = 1'b0;
                    end else begin
                        out_x_d       = cand_x_q;
                        out_y_d       = cand_y_q;
                        piece_valid_d = 1'b1;
                    end
                end else if (fail_q) begin
                    blocked_d = 1'b1;
                    if ((cmd_q == CMD_DOWN) && (LOCK_ON_DOWN != 0)) begin
                        locked_d      = 1'b1;
                        piece_valid_d = 1'b0;
                    end
                end else begin
                    out_x_d = cand_x_q;
                    out_y_d = cand_y_q;
                    moved_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmd_q         <= CMD_LEFT;
            is_load_q     <= 1'b0;
            fail_q        <= 1'b0;
            cnt_q         <= 2'd0;
            cand_x_q      <= '0;
            cand_y_q      <= '0;
            oob_q         <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            piece_valid_q <= 1'b0;
            moved_q       <= 1'b0;
            blocked_q     <= 1'b0;
            locked_q      <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            is_load_q     <= is_load_d;
            fail_q        <= fail_d;
            cnt_q         <= cnt_d;
            cand_x_q      <= cand_x_d;
            cand_y_q      <= cand_y_d;
            oob_q         <= oob_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            piece_valid_q <= piece_valid_d;
            moved_q       <= moved_d;
            blocked_q     <= blocked_d;
            locked_q      <= locked_d;
            game_over_q   <= game_over_d;
        end
    end

    assign load_ready  = (state_q == ST_IDLE);
    assign cmd_ready   = (state_q == ST_IDLE) && piece_valid_q;
    assign outX        = out_x_q;
    assign outY        = out_y_q;
    assign piece_valid = piece_valid_q;
    assign moved       = moved_q;
    assign blocked     = blocked_q;
    assign locked      = locked_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_tetrimino_mover.sv
// ----------------------------------------------------------------------------
// tb_tetrimino_mover
// Directed bench for tetrimino_mover with a transaction-level reference model
// that is compared against the DUT outputs on every falling clock edge.
// ----------------------------------------------------------------------------
module tb_tetrimino_mover;

    localparam int PIV  = 1;
    localparam int LOCK = 1;

    logic            clk       = 1'b0;
    logic            reset_n   = 1'b1;
    logic            load      = 1'b0;
    logic            cmd_valid = 1'b0;
    logic [1:0]      cmd       = 2'd0;
    logic [3:0][2:0] inX       = '0;
    logic [3:0][2:0] inY       = '0;
    logic [7:0][7:0] board     = '0;

    logic            load_ready, cmd_ready, piece_valid;
    logic            moved, blocked, locked, game_over;
    logic [3:0][2:0] outX, outY;

    int checks = 0;
    int errors = 0;

    tetrimino_mover #(
        .PIVOT_IDX    (PIV),
        .LOCK_ON_DOWN (LOCK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .inX         (inX),
        .inY         (inY),
        .load_ready  (load_ready),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .board       (board),
        .outX        (outX),
        .outY        (outY),
        .piece_valid (piece_valid),
        .moved       (moved),
        .blocked     (blocked),
        .locked      (locked),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain integer geometry, result scheduled by latency
    // ------------------------------------------------------------------
    typedef struct packed {
        logic            pass;
        logic [3:0][2:0] r;
        logic [3:0][2:0] c;
    } res_t;

    function automatic res_t model_eval(input bit is_load, input int op,
                                        input logic [3:0][2:0] px, input logic [3:0][2:0] py,
                                        input logic [7:0][7:0] brd);
        res_t res;
        int r, c, nr, nc, pr, pc;
        res.pass = 1'b1;
        res.r    = '0;
        res.c    = '0;
        pr = int'(px[PIV]);
        pc = int'(py[PIV]);
        for (int k = 0; k < 4; k++) begin
            r  = int'(px[k]);
            c  = int'(py[k]);
            nr = r;
            nc = c;
            if (!is_load) begin
                case (op)
                    0:       nc = c - 1;
                    1:       nc = c + 1;
                    2:       nr = r + 1;
                    default: begin
                        nr = pr + (c - pc);
                        nc = pc - (r - pr);
                    end
                endcase
            end
            if (nr < 0 || nr > 7 || nc < 0 || nc > 7)
                res.pass = 1'b0;
            else if (brd[nr][nc])
                res.pass = 1'b0;
            res.r[k] = 3'(nr);
            res.c[k] = 3'(nc);
        end
        return res;
    endfunction

    bit              m_busy, m_load;
    int              m_cnt, m_cmd;
    res_t            m_pend;
    logic [3:0][2:0] exp_x, exp_y;
    bit              exp_pv, exp_moved, exp_blocked, exp_locked, exp_go;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy      <= 1'b0;
            m_load      <= 1'b0;
            m_cnt       <= 0;
            m_cmd       <= 0;
            m_pend      <= '0;
            exp_x       <= '0;
            exp_y       <= '0;
            exp_pv      <= 1'b0;
            exp_moved   <= 1'b0;
            exp_blocked <= 1'b0;
            exp_locked  <= 1'b0;
            exp_go      <= 1'b0;
        end else begin
            exp_moved   <= 1'b0;
            exp_blocked <= 1'b0;
            exp_locked  <= 1'b0;
            exp_go      <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    if (m_load) begin
                        if (m_pend.pass) begin
                            exp_x  <= m_pend.r;
                            exp_y  <= m_pend.c;
                            exp_pv <= 1'b1;
                        end else begin
                            exp_go <= 1'b1;
                            exp_pv <= 1'b0;
                        end
                    end else if (m_pend.pass) begin
                        exp_x     <= m_pend.r;
                        exp_y     <= m_pend.c;
                        exp_moved <= 1'b1;
                    end else begin
                        exp_blocked <= 1'b1;
                        if (m_cmd == 2 && LOCK != 0) begin
                            exp_locked <= 1'b1;
                            exp_pv     <= 1'b0;
                        end
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (load) begin
                m_busy <= 1'b1;
                m_load <= 1'b1;
                m_cnt  <= 4;
                m_pend <= model_eval(1'b1, 0, inX, inY, board);
            end else if (cmd_valid && exp_pv) begin
                m_busy <= 1'b1;
                m_load <= 1'b0;
                m_cmd  <= int'(cmd);
                m_cnt  <= 5;
                m_pend <= model_eval(1'b0, int'(cmd), exp_x, exp_y, board);
            end
        end
    end

    always @(negedge clk) begin
        check("outX", outX, exp_x);
        check("outY", outY, exp_y);
        check("piece_valid", piece_valid, exp_pv);
        check("pulses", {game_over, locked, blocked, moved},
              {exp_go, exp_locked, exp_blocked, exp_moved});
        check("load_ready", load_ready, !m_busy);
        check("cmd_ready", cmd_ready, !m_busy && exp_pv);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Present one request for a single cycle, then count falling edges
    // until the mover is idle again; lat is the accept-to-result latency.
    task automatic issue(input bit ld, input bit cv, input logic [1:0] op,
                         input logic [3:0][2:0] x, input logic [3:0][2:0] y,
                         output int lat, output logic [3:0] pulses);
        @(negedge clk);
        load      = ld;
        cmd_valid = cv;
        cmd       = op;
        inX       = x;
        inY       = y;
        @(posedge clk);
        @(negedge clk);
        load      = 1'b0;
        cmd_valid = 1'b0;
        lat = 0;
        while (!load_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!load_ready) check("idle timeout", load_ready, 1'b1);
        pulses = {game_over, locked, blocked, moved};
    endtask

    localparam logic [3:0][2:0] ROW0  = {3'd0, 3'd0, 3'd0, 3'd0};
    localparam logic [3:0][2:0] ROW2  = {3'd2, 3'd2, 3'd2, 3'd2};
    localparam logic [3:0][2:0] ROW3  = {3'd3, 3'd3, 3'd3, 3'd3};
    localparam logic [3:0][2:0] C2345 = {3'd5, 3'd4, 3'd3, 3'd2};
    localparam logic [3:0][2:0] C0123 = {3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        int lat;
        logic [3:0] p;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset piece_valid", piece_valid, 1'b0);
        check("reset outY", outY, 12'h0);
        check("reset load_ready", load_ready, 1'b1);
        check("reset cmd_ready", cmd_ready, 1'b0);
        #2 reset_n = 1'b1;

        // command without a piece is ignored
        issue(1'b0, 1'b1, 2'd1, ROW0, ROW0, lat, p);
        check("no-piece cmd ignored", lat, 0);

        // load, then RIGHT x3 against the right wall
        issue(1'b1, 1'b0, 2'd0, ROW0, C2345, lat, p);
        check("load latency", lat, 5);
        check("load pulses", p, 4'b0000);
        check("load outY", outY, {3'd5, 3'd4, 3'd3, 3'd2});
        check("load piece_valid", piece_valid, 1'b1);
        issue(1'b0, 1'b1, 2'd1, ROW0, ROW0, lat, p);
        check("right1 latency", lat, 6);
        check("right1 pulses", p, 4'b0001);
        issue(1'b0, 1'b1, 2'd1, ROW0, ROW0, lat, p);
        check("right2 pulses", p, 4'b0001);
        issue(1'b0, 1'b1, 2'd1, ROW0, ROW0, lat, p);
        check("right3 latency", lat, 6);
        check("right3 pulses", p, 4'b0010);
        check("right3 outY", outY, {3'd7, 3'd6, 3'd5, 3'd4});

        // replace piece while valid; LEFT at column 0 must not wrap to 7
        issue(1'b1, 1'b0, 2'd0, ROW0, C0123, lat, p);
        issue(1'b0, 1'b1, 2'd0, ROW0, ROW0, lat, p);
        check("left wall pulses", p, 4'b0010);
        check("left wall outY", outY, {3'd3, 3'd2, 3'd1, 3'd0});

        // DOWN at the floor locks the piece
        issue(1'b1, 1'b0, 2'd0, {3'd7, 3'd7, 3'd6, 3'd6}, {3'd4, 3'd3, 3'd4, 3'd3}, lat, p);
        issue(1'b0, 1'b1, 2'd2, ROW0, ROW0, lat, p);
        check("lock pulses", p, 4'b0110);
        check("lock piece_valid", piece_valid, 1'b0);
        check("lock cmd_ready", cmd_ready, 1'b0);

        // rotate I-piece about block 1
        issue(1'b1, 1'b0, 2'd0, ROW3, C2345, lat, p);
        issue(1'b0, 1'b1, 2'd3, ROW0, ROW0, lat, p);
        check("rot latency", lat, 6);
        check("rot pulses", p, 4'b0001);
        check("rot outX", outX, {3'd5, 3'd4, 3'd3, 3'd2});
        check("rot outY", outY, {3'd3, 3'd3, 3'd3, 3'd3});

        // same rotation with board[5][3] occupied
        board[5][3] = 1'b1;
        issue(1'b1, 1'b0, 2'd0, ROW3, C2345, lat, p);
        issue(1'b0, 1'b1, 2'd3, ROW0, ROW0, lat, p);
        check("rot blocked pulses", p, 4'b0010);
        check("rot blocked outX", outX, {3'd3, 3'd3, 3'd3, 3'd3});
        board = '0;

        // vertical piece on the left edge cannot rotate (no wall kick)
        issue(1'b1, 1'b0, 2'd0, {3'd5, 3'd4, 3'd3, 3'd2}, ROW0, lat, p);
        issue(1'b0, 1'b1, 2'd3, ROW0, ROW0, lat, p);
        check("rot edge pulses", p, 4'b0010);

        // load overlapping board[0][3]
        board[0][3] = 1'b1;
        issue(1'b1, 1'b0, 2'd0, ROW0, C2345, lat, p);
        check("game_over latency", lat, 5);
        check("game_over pulses", p, 4'b1000);
        check("game_over piece_valid", piece_valid, 1'b0);
        check("game_over outX kept", outX, {3'd5, 3'd4, 3'd3, 3'd2});
        board = '0;

        // load wins over a simultaneous command
        issue(1'b1, 1'b0, 2'd0, ROW0, C2345, lat, p);
        issue(1'b1, 1'b1, 2'd1, ROW2, C2345, lat, p);
        check("load priority latency", lat, 5);
        check("load priority outX", outX, {3'd2, 3'd2, 3'd2, 3'd2});

        // reset during CHECK cycle 2 of a LEFT move
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = 2'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async reset outY", outY, 12'h0);
        check("async reset outX", outX, 12'h0);
        check("async reset piece_valid", piece_valid, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post reset load_ready", load_ready, 1'b1);
        check("post reset pulses", {game_over, locked, blocked, moved}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
